// File: rtl/packet_add_pkg.sv
// Shared types for packet_add_nch: the per-packet lane operation and the
// packet-framing FSM states.
package packet_add_pkg;

   typedef enum logic [1:0] {
      MODE_PASS = 2'b00,
      MODE_ADD  = 2'b01,
      MODE_SUB  = 2'b10,
      MODE_XOR  = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      ST_SOP  = 2'b00,
      ST_BODY = 2'b01,
      ST_DROP = 2'b10
   } state_t;

endpackage

// File: rtl/pkt_fifo.sv
// Synchronous FIFO with full/empty flags; read data is zero whenever the FIFO
// is empty so the output bus is clean straight out of reset.
module pkt_fifo
   import packet_add_pkg::*;
#(
   parameter int WIDTH = 33,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      wr_ptr_d;
   logic [AW:0]      rd_ptr_q;
   logic [AW:0]      rd_ptr_d;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_wr;
   logic             do_rd;

   // Extra pointer MSB distinguishes full from empty when the addresses match.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign rd_data = empty ? {WIDTH{1'b0}} : mem[rd_ptr_q[AW-1:0]];

   always_comb begin
      do_wr    = wr_en && !full;
      do_rd    = rd_en && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_wr) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_rd) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= {(AW+1){1'b0}};
         rd_ptr_q <= {(AW+1){1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr_q[AW-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/packet_add_nch.sv
// Multi-lane packet operator: applies pass/add/sub/xor with a per-packet offset
// to every lane, truncates oversize packets. Define PACKET_ADD_SAT_EN for saturating add/sub.
module packet_add_nch
   import packet_add_pkg::*;
#(
   parameter int DW        = 8,
   parameter int NCH       = 4,
   parameter int DD        = 16,
   parameter int MAX_BEATS = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH*DW-1:0] s_tdata,
   input  logic              s_tvalid,
   input  logic              s_tlast,
   output logic              s_tready,
   input  logic [DW-1:0]     cfg_offset,
   input  logic [1:0]        cfg_mode,
   output logic [NCH*DW-1:0] m_tdata,
   output logic              m_tvalid,
   output logic              m_tlast,
   input  logic              m_tready,
   output logic [15:0]       pkt_cnt,
   output logic              trunc_err
);

   localparam int CW = $clog2(MAX_BEATS + 1);
   localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE   = CW'(32'd1);
   localparam logic [CW-1:0] LAST_BODY = CW'(MAX_BEATS - 1);

   state_t            state_q;
   state_t            state_d;
   logic [CW-1:0]     beat_cnt_q;
   logic [CW-1:0]     beat_cnt_d;
   mode_t             mode_q;
   mode_t             mode_d;
   logic [DW-1:0]     offset_q;
   logic [DW-1:0]     offset_d;
   logic [15:0]       pkt_cnt_q;
   logic [15:0]       pkt_cnt_d;
   logic              trunc_err_q;
   logic              trunc_err_d;

   mode_t             op_mode;
   logic [DW-1:0]     op_offset;
   logic [NCH*DW-1:0] wr_beat;
   logic              wr_last;
   logic              fifo_wr;
   logic              fifo_full;
   logic              fifo_empty;
   logic [NCH*DW:0]   fifo_rd_data;
   logic              accept;

   function automatic logic [DW-1:0] lane_op(input mode_t mode,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
`ifdef PACKET_ADD_SAT_EN
      logic [DW:0] wide;
`endif
      case (mode)
         MODE_PASS: lane_op = a;
         MODE_ADD: begin
`ifdef PACKET_ADD_SAT_EN
            wide    = {1'b0, a} + {1'b0, b};
            lane_op = wide[DW] ? {DW{1'b1}} : wide[DW-1:0];
`else
            lane_op = a + b;
`endif
         end
         MODE_SUB: begin
`ifdef PACKET_ADD_SAT_EN
            // Borrow out of the extended difference means the result went below zero.
            wide    = {1'b0, a} - {1'b0, b};
            lane_op = wide[DW] ? {DW{1'b0}} : wide[DW-1:0];
`else
            lane_op = a - b;
`endif
         end
         MODE_XOR: lane_op = a ^ b;
         default:  lane_op = a;
      endcase
   endfunction

   // DROP swallows the rest of a truncated packet regardless of buffer space.
   assign s_tready  = (state_q == ST_DROP) || !fifo_full;
   assign accept    = s_tvalid && s_tready;
   assign m_tvalid  = !fifo_empty;
   assign m_tdata   = fifo_rd_data[NCH*DW-1:0];
   assign m_tlast   = fifo_rd_data[NCH*DW];
   assign pkt_cnt   = pkt_cnt_q;
   assign trunc_err = trunc_err_q;

   // The first beat of a packet uses the live config; later beats use the latched copy.
   always_comb begin
      if (state_q == ST_SOP) begin
         op_mode   = mode_t'(cfg_mode);
         op_offset = cfg_offset;
      end else begin
         op_mode   = mode_q;
         op_offset = offset_q;
      end
      wr_beat = {(NCH*DW){1'b0}};
      for (int i = 0; i < NCH; i++) begin
         wr_beat[i*DW +: DW] = lane_op(op_mode, s_tdata[i*DW +: DW], op_offset);
      end
   end

   always_comb begin
      state_d     = state_q;
      beat_cnt_d  = beat_cnt_q;
      mode_d      = mode_q;
      offset_d    = offset_q;
      trunc_err_d = 1'b0;
      wr_last     = s_tlast;
      fifo_wr     = 1'b0;
      if (accept) begin
         case (state_q)
            ST_SOP: begin
               mode_d   = mode_t'(cfg_mode);
               offset_d = cfg_offset;
               fifo_wr  = 1'b1;
               if (s_tlast) begin
                  state_d    = ST_SOP;
                  beat_cnt_d = CNT_ZERO;
               end else begin
                  state_d    = ST_BODY;
                  beat_cnt_d = CNT_ONE;
               end
            end
            ST_BODY: begin
               fifo_wr = 1'b1;
               if (s_tlast) begin
                  state_d    = ST_SOP;
                  beat_cnt_d = CNT_ZERO;
               end else if (beat_cnt_q == LAST_BODY) begin
                  // This is beat MAX_BEATS: close the packet early and drop the rest.
                  state_d     = ST_DROP;
                  beat_cnt_d  = CNT_ZERO;
                  wr_last     = 1'b1;
                  trunc_err_d = 1'b1;
               end else begin
                  state_d    = ST_BODY;
                  beat_cnt_d = beat_cnt_q + CNT_ONE;
               end
            end
            ST_DROP: begin
               if (s_tlast) begin
                  state_d = ST_SOP;
               end else begin
                  state_d = ST_DROP;
               end
            end
            default: begin
               state_d    = ST_SOP;
               beat_cnt_d = CNT_ZERO;
            end
         endcase
      end else begin
         state_d = state_q;
      end
      if (m_tvalid && m_tready && m_tlast) begin
         pkt_cnt_d = pkt_cnt_q + 16'd1;
      end else begin
         pkt_cnt_d = pkt_cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_SOP;
         beat_cnt_q  <= CNT_ZERO;
         mode_q      <= MODE_PASS;
         offset_q    <= {DW{1'b0}};
         pkt_cnt_q   <= 16'd0;
         trunc_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         beat_cnt_q  <= beat_cnt_d;
         mode_q      <= mode_d;
         offset_q    <= offset_d;
         pkt_cnt_q   <= pkt_cnt_d;
         trunc_err_q <= trunc_err_d;
      end
   end

   pkt_fifo #(
      .WIDTH (NCH*DW + 1),
      .DEPTH (DD)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (fifo_wr),
      .wr_data ({wr_last, wr_beat}),
      .rd_en   (m_tready),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

endmodule

// File: tb/tb_packet_add_nch.sv
// Self-checking bench for packet_add_nch: randomized packets against a
// beat-level reference model; follows PACKET_ADD_SAT_EN when defined.
module tb_packet_add_nch;

   localparam int DW   = 8;
   localparam int NCH  = 4;
   localparam int DD   = 16;
   localparam int MAXB = 4;
   localparam int TW   = NCH*DW;

   logic          clk = 1'b0;
   logic          rst;
   logic [TW-1:0] s_tdata;
   logic          s_tvalid;
   logic          s_tlast;
   logic          s_tready;
   logic [DW-1:0] cfg_offset;
   logic [1:0]    cfg_mode;
   logic [TW-1:0] m_tdata;
   logic          m_tvalid;
   logic          m_tlast;
   logic          m_tready;
   logic [15:0]   pkt_cnt;
   logic          trunc_err;

   int checks = 0;
   int errors = 0;

   logic [TW:0] exp_q[$];
   logic [TW:0] obs_q[$];

   bit            md_in_pkt;
   bit            md_drop;
   int            md_idx;
   logic [1:0]    md_mode;
   logic [DW-1:0] md_off;
   int            exp_pkts;
   int            exp_trunc;
   int            trunc_seen;

   always #5 clk = ~clk;

   packet_add_nch #(.DW(DW), .NCH(NCH), .DD(DD), .MAX_BEATS(MAXB)) dut (
      .clk(clk), .rst(rst),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
      .cfg_offset(cfg_offset), .cfg_mode(cfg_mode),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
      .pkt_cnt(pkt_cnt), .trunc_err(trunc_err)
   );

   function automatic logic [DW-1:0] ref_lane(input logic [1:0] mode, input int a, input int b);
      int r;
      int top;
      top = (1 << DW) - 1;
      case (mode)
         2'b00: r = a;
         2'b01: begin
            r = a + b;
`ifdef PACKET_ADD_SAT_EN
            if (r > top) r = top;
`else
            r = r % (top + 1);
`endif
         end
         2'b10: begin
            r = a - b;
`ifdef PACKET_ADD_SAT_EN
            if (r < 0) r = 0;
`else
            if (r < 0) r = r + top + 1;
`endif
         end
         default: r = a ^ b;
      endcase
      return r[DW-1:0];
   endfunction

   // Reference model: one call per accepted input beat.
   task automatic model_accept(input logic [TW-1:0] d, input logic last,
                               input logic [DW-1:0] off, input logic [1:0] mode);
      logic [TW-1:0] r;
      logic          olast;
      if (md_drop) begin
         if (last) md_drop = 1'b0;
         return;
      end
      if (!md_in_pkt) begin
         md_in_pkt = 1'b1;
         md_idx    = 0;
         md_mode   = mode;
         md_off    = off;
      end
      md_idx++;
      for (int i = 0; i < NCH; i++) r[i*DW +: DW] = ref_lane(md_mode, int'(d[i*DW +: DW]), int'(md_off));
      olast = last;
      if (!last && md_idx == MAXB) begin
         olast   = 1'b1;
         md_drop = 1'b1;
         exp_trunc++;
      end
      if (olast) begin
         md_in_pkt = 1'b0;
         exp_pkts++;
      end
      exp_q.push_back({olast, r});
   endtask

   // Drive one cycle at the falling edge, record both handshakes, advance a cycle.
   task automatic step(input logic v, input logic [TW-1:0] d, input logic l,
                       input logic [DW-1:0] off, input logic [1:0] mode,
                       input logic rdy, output logic acc);
      s_tvalid   = v;
      s_tdata    = d;
      s_tlast    = l;
      cfg_offset = off;
      cfg_mode   = mode;
      m_tready   = rdy;
      acc = v && (s_tready === 1'b1);
      if (acc) model_accept(d, l, off, mode);
      if (m_tvalid === 1'b1 && m_tready) obs_q.push_back({m_tlast, m_tdata});
      if (trunc_err === 1'b1) trunc_seen++;
      @(negedge clk);
   endtask

   task automatic drain(input string name);
      logic a;
      int   n;
      n = 0;
      while (m_tvalid === 1'b1 && n < 200) begin
         step(1'b0, {TW{1'b0}}, 1'b0, 8'h00, 2'b00, 1'b1, a);
         n++;
      end
      step(1'b0, {TW{1'b0}}, 1'b0, 8'h00, 2'b00, 1'b1, a);
      checks++;
      if (m_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL %s_drain m_tvalid got %b expected 0", name, m_tvalid);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = {TW{1'b0}};
      cfg_offset = 8'h00; cfg_mode = 2'b00; m_tready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      exp_q.delete(); obs_q.delete();
      md_in_pkt = 1'b0; md_drop = 1'b0; md_idx = 0;
      exp_pkts = 0; exp_trunc = 0; trunc_seen = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b expected 0", m_tvalid); end
      checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b expected 0", m_tlast); end
      checks++; if (m_tdata !== {TW{1'b0}}) begin errors++; $display("FAIL rst_tdata got %h expected 0", m_tdata); end
      checks++; if (trunc_err !== 1'b0) begin errors++; $display("FAIL rst_trunc got %b expected 0", trunc_err); end
      checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL rst_tready got %b expected 1", s_tready); end
      checks++; if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL rst_pktcnt got %0d expected 0", pkt_cnt); end
   endtask

   task automatic test_add_basic();
      logic a;
      logic [TW:0] want;
      exp_q.delete(); obs_q.delete();
      for (int b = 0; b < 3; b++) begin
         step(1'b1, {NCH{8'h10}}, (b == 2), 8'h05, 2'b01, 1'b1, a);
         if (b == 0) begin
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== {NCH{8'h15}}) begin
               errors++;
               $display("FAIL add_latency got valid=%b data=%h expected valid=1 data=%h", m_tvalid, m_tdata, {NCH{8'h15}});
            end
         end
      end
      drain("add");
      checks++;
      if (obs_q.size() != 3) begin errors++; $display("FAIL add_count got %0d expected 3", obs_q.size()); end
      for (int i = 0; i < obs_q.size() && i < 3; i++) begin
         want = {(i == 2) ? 1'b1 : 1'b0, {NCH{8'h15}}};
         checks++;
         if (obs_q[i] !== want) begin errors++; $display("FAIL add_beat%0d got %h expected %h", i, obs_q[i], want); end
      end
      checks++;
      if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL add_pktcnt got %0d expected 1", pkt_cnt); end
   endtask

   task automatic test_overflow();
      logic a;
      logic [DW-1:0] want_add, want_sub;
      int len;
`ifdef PACKET_ADD_SAT_EN
      want_add = 8'hFF; want_sub = 8'h00;
`else
      want_add = 8'h03; want_sub = 8'hFD;
`endif
      exp_q.delete(); obs_q.delete();
      step(1'b1, {NCH{8'hFE}}, 1'b1, 8'h05, 2'b01, 1'b1, a);
      step(1'b1, {NCH{8'h02}}, 1'b1, 8'h05, 2'b10, 1'b1, a);
      for (int p = 0; p < 12; p++) begin
         len = $urandom_range(1, 3);
         for (int b = 0; b < len; b++)
            step(1'b1, TW'($urandom()), (b == len - 1), 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), 1'b1, a);
      end
      drain("ovf");
      checks++;
      if (obs_q.size() < 2 || obs_q[0] !== {1'b1, {NCH{want_add}}}) begin
         errors++; $display("FAIL ovf_add got %h expected %h", (obs_q.size() > 0) ? obs_q[0] : {(TW+1){1'b0}}, {1'b1, {NCH{want_add}}});
      end
      checks++;
      if (obs_q.size() < 2 || obs_q[1] !== {1'b1, {NCH{want_sub}}}) begin
         errors++; $display("FAIL ovf_sub got %h expected %h", (obs_q.size() > 1) ? obs_q[1] : {(TW+1){1'b0}}, {1'b1, {NCH{want_sub}}});
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_count got %0d expected %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_beat%0d got %h expected %h", i, obs_q[i], exp_q[i]); end
      end
      checks++;
      if (pkt_cnt !== exp_pkts[15:0]) begin errors++; $display("FAIL ovf_pktcnt got %0d expected %0d", pkt_cnt, exp_pkts); end
   endtask

   task automatic test_cfg_hold();
      logic a;
      logic [TW-1:0] d[3];
      logic [TW:0] want;
      exp_q.delete(); obs_q.delete();
      for (int b = 0; b < 3; b++)
         for (int l = 0; l < NCH; l++) d[b][l*DW +: DW] = 8'($urandom_range(0, 254));
      step(1'b1, d[0], 1'b0, 8'h01, 2'b01, 1'b1, a);
      step(1'b1, d[1], 1'b0, 8'h80, 2'b11, 1'b1, a);
      step(1'b1, d[2], 1'b1, 8'h80, 2'b10, 1'b1, a);
      drain("cfg");
      checks++;
      if (obs_q.size() != 3) begin errors++; $display("FAIL cfg_count got %0d expected 3", obs_q.size()); end
      for (int i = 0; i < obs_q.size() && i < 3; i++) begin
         // Lanes are at most 0xFE, so adding 1 per lane never carries between lanes.
         want = {(i == 2) ? 1'b1 : 1'b0, d[i] + {NCH{8'h01}}};
         checks++;
         if (obs_q[i] !== want) begin errors++; $display("FAIL cfg_beat%0d got %h expected %h", i, obs_q[i], want); end
      end
   endtask

   task automatic test_backpressure();
      logic a;
      logic [TW-1:0] d[DD+2];
      int idx;
      exp_q.delete(); obs_q.delete();
      foreach (d[i]) d[i] = TW'($urandom());
      idx = 0;
      for (int c = 0; c < 40; c++) begin
         if (c == 24) begin
            checks++;
            if (idx != DD) begin errors++; $display("FAIL bp_accepted got %0d expected %0d", idx, DD); end
            checks++;
            if (s_tready !== 1'b0) begin errors++; $display("FAIL bp_tready got %b expected 0", s_tready); end
         end
         step(idx < DD + 2, (idx < DD + 2) ? d[idx] : {TW{1'b0}}, (idx % 3 == 2),
              8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), (c >= 24), a);
         if (a) idx++;
      end
      drain("bp");
      checks++;
      if (idx != DD + 2) begin errors++; $display("FAIL bp_total got %0d expected %0d", idx, DD + 2); end
      checks++;
      if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count got %0d expected %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat%0d got %h expected %h", i, obs_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_oversize();
      logic a;
      logic [1:0] mode;
      exp_q.delete(); obs_q.delete();
      trunc_seen = 0;
      mode = 2'($urandom_range(0, 3));
      for (int b = 0; b < 7; b++) step(1'b1, TW'($urandom()), (b == 6), 8'h33, mode, 1'b1, a);
      for (int b = 0; b < 2; b++) step(1'b1, TW'($urandom()), (b == 1), 8'h0F, 2'b01, 1'b1, a);
      drain("ovs");
      checks++;
      if (obs_q.size() != 6) begin errors++; $display("FAIL ovs_count got %0d expected 6", obs_q.size()); end
      checks++;
      if (obs_q.size() < 4 || obs_q[3][TW] !== 1'b1) begin errors++; $display("FAIL ovs_tlast4 beat 4 tlast missing, beats seen %0d", obs_q.size()); end
      checks++;
      if (trunc_seen != 1) begin errors++; $display("FAIL ovs_trunc got %0d pulses expected 1", trunc_seen); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovs_beat%0d got %h expected %h", i, obs_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_back_to_back();
      logic a;
      logic [TW-1:0] d;
      int pk, bt, len, cyc;
      exp_q.delete(); obs_q.delete();
      trunc_seen = 0; exp_trunc = 0;
      pk = 0; bt = 0; cyc = 0;
      len = $urandom_range(1, 6);
      d = TW'($urandom());
      while (pk < 30 && cyc < 3000) begin
         step(($urandom_range(0, 3) != 0), d, (bt == len - 1), 8'($urandom_range(0, 255)),
              2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7), a);
         cyc++;
         if (a) begin
            d = TW'($urandom());
            bt++;
            if (bt == len) begin bt = 0; pk++; len = $urandom_range(1, 6); end
         end
      end
      checks++;
      if (pk != 30) begin errors++; $display("FAIL b2b_timeout got %0d packets expected 30", pk); end
      drain("b2b");
      checks++;
      if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d expected %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_beat%0d got %h expected %h", i, obs_q[i], exp_q[i]); end
      end
      checks++;
      if (trunc_seen != exp_trunc) begin errors++; $display("FAIL b2b_trunc got %0d expected %0d", trunc_seen, exp_trunc); end
      checks++;
      if (pkt_cnt !== exp_pkts[15:0]) begin errors++; $display("FAIL b2b_pktcnt got %0d expected %0d", pkt_cnt, exp_pkts); end
   endtask

   task automatic test_reset_mid();
      logic a;
      logic [TW-1:0] d[3];
      logic [TW:0] want;
      for (int b = 0; b < 2; b++) step(1'b1, TW'($urandom()), 1'b0, 8'h07, 2'b01, 1'b0, a);
      do_reset();
      checks++;
      if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rmid_tvalid got %b expected 0", m_tvalid); end
      checks++;
      if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL rmid_pktcnt got %0d expected 0", pkt_cnt); end
      for (int b = 0; b < 3; b++)
         for (int l = 0; l < NCH; l++) d[b][l*DW +: DW] = 8'($urandom_range(3, 255));
      for (int b = 0; b < 3; b++) step(1'b1, d[b], (b == 2), 8'h03, 2'b10, 1'b1, a);
      drain("rmid");
      checks++;
      if (obs_q.size() != 3) begin errors++; $display("FAIL rmid_count got %0d expected 3", obs_q.size()); end
      for (int i = 0; i < obs_q.size() && i < 3; i++) begin
         // Lanes are at least 3, so subtracting 3 per lane never borrows.
         want = {(i == 2) ? 1'b1 : 1'b0, d[i] - {NCH{8'h03}}};
         checks++;
         if (obs_q[i] !== want) begin errors++; $display("FAIL rmid_beat%0d got %h expected %h", i, obs_q[i], want); end
      end
      checks++;
      if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL rmid_pktcnt_after got %0d expected 1", pkt_cnt); end
   endtask

   initial begin
      test_reset();
      test_add_basic();
      test_overflow();
      test_cfg_hold();
      test_backpressure();
      test_oversize();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
